// File: rtl/seq_frame_pkg.sv
// Shared definitions for the "101" sequence link: transmitter FSM states and
// the framing constants used by both the sending and receiving ends.
package seq_frame_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRE   = 2'd1,
      S_DATA  = 2'd2,
      S_GUARD = 2'd3
   } seq_tx_state_t;

   localparam logic [2:0] SEQ_PREAMBLE  = 3'b101;
   localparam int         SEQ_PRE_LEN   = 3;
   localparam logic       SEQ_IDLE_BIT  = 1'b0;
   localparam logic       SEQ_GUARD_BIT = 1'b0;

endpackage

// File: rtl/seq_frame_shreg.sv
// Parallel-in / serial-out payload register; the MSB is the next bit to send.
module seq_frame_shreg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              msb
);

   logic [DATA_W-1:0] data_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else if (load) begin
         data_reg <= din;
      end else if (shift) begin
         data_reg <= {data_reg[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = data_reg[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Bit-serial frame transmitter: sends preamble 101, the payload MSB-first and a
// guard 0 per accepted word; back-to-back frames leave no idle gap.
module seq_frame_tx
   import seq_frame_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_out,
   output logic              tx_active,
   output logic              frame_done
);

   // The counter also indexes the 3-bit preamble, so it needs at least 2 bits.
   localparam int CNT_W = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(SEQ_PRE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(DATA_W - 1);

   seq_tx_state_t    state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             tx_out_reg, tx_out_next;
   logic             tx_active_reg, tx_active_next;
   logic             frame_done_reg, frame_done_next;
   logic             accept;
   logic             shreg_msb;
   logic             shreg_shift;
   logic [3:0]       pre_vec;

   assign pre_vec     = {1'b0, SEQ_PREAMBLE};
   assign in_ready    = ((state_reg == S_IDLE) || (state_reg == S_GUARD)) && !rst;
   assign accept      = in_valid && in_ready;
   assign shreg_shift = (state_next == S_DATA);

   seq_frame_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shreg_shift),
      .din   (in_data),
      .msb   (shreg_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         tx_out_reg     <= SEQ_IDLE_BIT;
         tx_active_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         tx_out_reg     <= tx_out_next;
         tx_active_reg  <= tx_active_next;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next = S_IDLE;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            state_next = S_IDLE;
            if (accept) begin
               state_next = S_PRE;
               cnt_next   = CNT_PRE_LAST;
            end
         end
         S_PRE: begin
            state_next = S_PRE;
            cnt_next   = cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
               state_next = S_DATA;
               cnt_next   = CNT_DATA_LAST;
            end
         end
         S_DATA: begin
            state_next = S_DATA;
            cnt_next   = cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) begin
               state_next = S_GUARD;
               cnt_next   = '0;
            end
         end
         S_GUARD: begin
            state_next = S_IDLE;
            cnt_next   = '0;
            if (accept) begin
               state_next = S_PRE;
               cnt_next   = CNT_PRE_LAST;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered line lines up
   // with the state it belongs to, one cycle after accept.
   always_comb begin
      tx_out_next     = SEQ_IDLE_BIT;
      tx_active_next  = 1'b0;
      frame_done_next = 1'b0;
      case (state_next)
         S_PRE: begin
            tx_out_next    = pre_vec[cnt_next[1:0]];
            tx_active_next = 1'b1;
         end
         S_DATA: begin
            tx_out_next    = shreg_msb;
            tx_active_next = 1'b1;
         end
         S_GUARD: begin
            tx_out_next     = SEQ_GUARD_BIT;
            tx_active_next  = 1'b1;
            frame_done_next = 1'b1;
         end
         default: begin
            tx_out_next     = SEQ_IDLE_BIT;
            tx_active_next  = 1'b0;
            frame_done_next = 1'b0;
         end
      endcase
   end

   assign tx_out     = tx_out_reg;
   assign tx_active  = tx_active_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: vector table plus back-to-back and
// loopback-through-a-101-detector sequences.
module tb_seq_frame_tx;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       tx_out;
   logic       tx_active;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   seq_frame_tx #(
      .DATA_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx_out     (tx_out),
      .tx_active  (tx_active),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference "101" detector fed by the serial line (overlapping matches).
   localparam logic [1:0] D_NONE = 2'd0, D_1 = 2'd1, D_10 = 2'd2;
   logic [1:0] det_state;
   logic       seq_detected;

   always_ff @(posedge clk) begin
      if (rst) begin
         det_state <= D_NONE;
      end else begin
         case (det_state)
            D_NONE:  det_state <= tx_out ? D_1 : D_NONE;
            D_1:     det_state <= tx_out ? D_1 : D_10;
            D_10:    det_state <= tx_out ? D_1 : D_NONE;
            default: det_state <= D_NONE;
         endcase
      end
   end
   assign seq_detected = (det_state == D_10) && tx_out;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [7:0] data;
      logic       e_tx;
      logic       e_act;
      logic       e_fd;
      logic       e_rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line value j cycles after accept (j = 0 is the first preamble bit).
   function automatic logic frame_bit(input logic [7:0] w, input int j);
      if (j < 3)  return (j != 1);
      if (j < 11) return w[10-j];
      return 1'b0;
   endfunction

   task automatic add(input logic r, input logic v, input logic [7:0] d,
                      input logic etx, input logic eact, input logic efd, input logic erdy);
      vec_t x;
      x.rst = r; x.valid = v; x.data = d;
      x.e_tx = etx; x.e_act = eact; x.e_fd = efd; x.e_rdy = erdy;
      vecs.push_back(x);
   endtask

   // Accept from idle, then the frame cycles; optional input disturbance during
   // data bits, and optional reset in frame cycle abort_j (-1 for none).
   task automatic add_frame(input logic [7:0] w, input bit disturb, input int abort_j);
      add(1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 12; j++) begin
         logic v;
         logic [7:0] d;
         logic r;
         v = 1'b0;
         d = w;
         r = (j == abort_j);
         if (disturb && j >= 3 && j <= 10) begin
            v = j[0];
            d = 8'h3C;
         end
         add(r, v, d, frame_bit(w, j), 1'b1, (j == 11), (j == 11) && !r);
         if (r) return;
      end
   endtask

   initial begin
      int a1, a2, det_cnt, det_cyc;
      logic tx_log[48];
      logic act_log[48];
      logic fd_log[48];

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add_frame(8'hA5, 1'b0, -1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add_frame(8'hA5, 1'b1, -1);
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add_frame(8'hA5, 1'b0, 5);
      for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; in_valid = vecs[i].valid; in_data = vecs[i].data;
         #1;
         $display("vec %0d rst=%0b v=%0b d=%02h tx=%0b act=%0b fd=%0b rdy=%0b",
                  i, rst, in_valid, in_data, tx_out, tx_active, frame_done, in_ready);
         check($sformatf("vec%0d tx_out", i),     tx_out,     vecs[i].e_tx);
         check($sformatf("vec%0d tx_active", i),  tx_active,  vecs[i].e_act);
         check($sformatf("vec%0d frame_done", i), frame_done, vecs[i].e_fd);
         check($sformatf("vec%0d in_ready", i),   in_ready,   vecs[i].e_rdy);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; in_valid = 1'b0;

      // Back-to-back: in_valid held high, FF then 00.
      a1 = -1; a2 = -1;
      in_valid = 1'b1; in_data = 8'hFF;
      for (int c = 0; c < 48; c++) begin
         logic acc;
         #1;
         acc = in_valid && in_ready;
         tx_log[c] = tx_out; act_log[c] = tx_active; fd_log[c] = frame_done;
         @(posedge clk);
         #1;
         if (acc) begin
            if (a1 < 0) begin
               a1 = c; in_data = 8'h00;
            end else if (a2 < 0) begin
               a2 = c; in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      $display("b2b accepts at %0d and %0d", a1, a2);
      if (a1 < 0 || a2 < 0 || a1 + 25 >= 48) begin
         n_cmp++; n_bad++;
         $display("FAIL b2b_accepts: got a1=%0d a2=%0d expected two accepts 12 apart", a1, a2);
      end else begin
         check("b2b_accept_spacing", a2 - a1, 12);
         for (int j = 0; j < 24; j++) begin
            logic [7:0] w;
            w = (j < 12) ? 8'hFF : 8'h00;
            check($sformatf("b2b tx_out j%0d", j), tx_log[a1+1+j], frame_bit(w, j % 12));
            check($sformatf("b2b tx_active j%0d", j), act_log[a1+1+j], 1'b1);
            check($sformatf("b2b frame_done j%0d", j), fd_log[a1+1+j], (j % 12) == 11);
         end
         check("b2b idle after", act_log[a1+25], 1'b0);
      end

      // Loopback: 00 payload must yield exactly one detection, on the third preamble bit.
      repeat (2) @(posedge clk);
      #1;
      det_cnt = 0; det_cyc = -1;
      in_valid = 1'b1; in_data = 8'h00;
      #1;
      check("loop in_ready", in_ready, 1'b1);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) #1;
         if (seq_detected) begin
            det_cnt++;
            if (det_cyc < 0) det_cyc = c;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      $display("loopback detections=%0d first at cycle %0d", det_cnt, det_cyc);
      check("loop det count", det_cnt, 1);
      check("loop det cycle", det_cyc, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
